fixed_to_float: RTL and testbench
=================================

Name: fixed_to_float

Overview:
- Iterative converter from the FISR datapath's unsigned fixed-point format (31-bit, 23 fractional bits) back to IEEE-754 single precision.
- It is the inverse of the float_to_fixed converter. It lets a FISR result (fixed_out) be returned to software or a float bus as a float.
- Uses the same start/complete pulse handshake as float_to_fixed. Normalisation is done one bit per cycle (no barrel shifter, no priority encoder).

Parameters:
- IN_W, 31, input width in bits; legal range 24..32.
- FRAC_BITS, 23, number of fractional bits in fixed_in; legal range 0..IN_W-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  request conversion; sampled only in IDLE.
- fixed_in  input  IN_W  unsigned fixed-point operand; sampled on the accepting edge only.
- float_out  output  32  IEEE-754 result; held until the next conversion packs.
- complete  output  1  one-cycle pulse; float_out is valid while it is high.

Behaviour:
- Reset (synchronous, active-high): complete=0, float_out=0, state=IDLE, internal registers cleared. Reset mid-conversion aborts it; no complete pulse is produced.
- Registers:
  - work: IN_W bits.
  - exp: 9 bits, initialised to 150-FRAC_BITS (127 for the default).
- Normalisation target: leading one at work bit 23.
- State machine:
  - IDLE: complete<=0. If start, then work<=fixed_in, exp<=150-FRAC_BITS, go to CHECK; otherwise stay.
  - CHECK:
    - work==0: float_out<=0, go to DONE.
    - Else if any work[IN_W-1:24] set: go to SHIFT_RIGHT.
    - Else if work[23]==0: go to SHIFT_LEFT.
    - Else: go to PACK.
  - SHIFT_RIGHT: work<=work>>1, exp<=exp+1. Go to PACK when the post-shift work[IN_W-1:24] is all zero; otherwise stay. Shifted-out bits are truncated (round toward zero, matching float_to_fixed).
  - SHIFT_LEFT: work<=work<<1, exp<=exp-1. Go to PACK when the post-shift work[23]==1; otherwise stay.
  - PACK: float_out<={1'b0, exp[7:0], work[22:0]}, go to DONE.
  - DONE: complete<=1, go to IDLE.
- complete behaviour:
  - complete is high for exactly one cycle, because IDLE clears it.
  - start is accepted in the same IDLE cycle in which complete is high, so back-to-back conversions are possible.
- Latency: let p = index of the leading one of fixed_in and k = |p-23|.
  - Nonzero input: complete is first seen high after rising edge 4+k, counting the start-accepting edge as edge 1.
  - Zero input: after edge 3.
- start is ignored in every state except IDLE. fixed_in may change freely after the accepting edge.
- Sign bit is always 0 (input is unsigned). No denormal, Inf or NaN outputs.
  - Default exp range is 104..134, so no under/overflow.
  - For non-default parameters, exp[8] never needs to be checked, by the legal-range constraint.
- float_out changes only in CHECK (zero case) or PACK. It is otherwise stable, including while complete is low.

Test Plan:
- Reset, then fixed_in=0x0800000 (1.0) with a 1-cycle start: float_out=0x3F800000, complete after edge 4 for exactly 1 cycle. Then fixed_in=0x0C00000 (1.5): 0x3FC00000, latency 4.
- fixed_in=0x0400000 (0.5): 0x3F000000, latency 5. Then fixed_in=0x0000001: 0x34000000, latency 27.
- fixed_in=0x7FFFFFFF: 0x437FFFFF (exp 0x86, truncated mantissa), latency 11. fixed_in=0: 0x00000000, latency 3.
- Hold start high continuously with new fixed_in each accept:
  - Conversions run back-to-back; the next start is accepted in the cycle complete is high.
  - start and fixed_in changes during busy states are ignored.
- Assert reset during SHIFT_LEFT of the 0x0000001 conversion: next cycle complete=0 and float_out=0, with no pulse. A following 1.0 conversion gives 0x3F800000.
- Round trip: 1000 random positive floats with exponent in 104..134 go through float_to_fixed then fixed_to_float. Output must equal the input with mantissa bits below the fixed LSB truncated.

Source files
------------

// File: rtl/fixed_to_float.sv
// Iterative unsigned fixed-point to IEEE-754 single converter.
// Normalises one bit per cycle until the leading one sits at work bit 23, then packs.
module fixed_to_float #(
    parameter int IN_W      = 31,
    parameter int FRAC_BITS = 23
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] fixed_in,
    output logic [31:0]     float_out,
    output logic            complete
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT_RIGHT,
        S_SHIFT_LEFT,
        S_PACK,
        S_DONE
    } state_t;

    localparam logic [8:0]      EXP_INIT = 9'(150 - FRAC_BITS);
    // Bits above the hidden-one position; empty when IN_W is exactly 24.
    localparam logic [IN_W-1:0] LOW_MASK = IN_W'((64'd1 << 24) - 64'd1);
    localparam logic [IN_W-1:0] HI_MASK  = ~LOW_MASK;

    state_t          state_q, state_d;
    logic [IN_W-1:0] work_q, work_d;
    logic [8:0]      exp_q, exp_d;
    logic [31:0]     float_q, float_d;
    logic            complete_q, complete_d;

    logic [IN_W-1:0] work_shr, work_shl;
    logic            hi_now, hi_shr;
    logic            unused_exp_msb;

    assign work_shr       = work_q >> 1;
    assign work_shl       = work_q << 1;
    assign hi_now         = |(work_q & HI_MASK);
    assign hi_shr         = |(work_shr & HI_MASK);
    assign unused_exp_msb = exp_q[8];

    assign float_out = float_q;
    assign complete  = complete_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            exp_q      <= '0;
            float_q    <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            exp_q      <= exp_d;
            float_q    <= float_d;
            complete_q <= complete_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (work_q == '0)     state_d = S_DONE;
                else if (hi_now)      state_d = S_SHIFT_RIGHT;
                else if (!work_q[23]) state_d = S_SHIFT_LEFT;
                else                  state_d = S_PACK;
            end
            S_SHIFT_RIGHT: begin
                if (!hi_shr) state_d = S_PACK;
            end
            S_SHIFT_LEFT: begin
                if (work_shl[23]) state_d = S_PACK;
            end
            S_PACK:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        work_d     = work_q;
        exp_d      = exp_q;
        float_d    = float_q;
        complete_d = complete_q;
        case (state_q)
            S_IDLE: begin
                complete_d = 1'b0;
                if (start) begin
                    work_d = fixed_in;
                    exp_d  = EXP_INIT;
                end
            end
            S_CHECK: begin
                if (work_q == '0) float_d = '0;
            end
            // Bits shifted out on the right are dropped: round toward zero.
            S_SHIFT_RIGHT: begin
                work_d = work_shr;
                exp_d  = exp_q + 9'd1;
            end
            S_SHIFT_LEFT: begin
                work_d = work_shl;
                exp_d  = exp_q - 9'd1;
            end
            S_PACK: begin
                float_d = {1'b0, exp_q[7:0], work_q[22:0]};
            end
            S_DONE: begin
                complete_d = 1'b1;
            end
            default: begin
                complete_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed and round-trip bench for fixed_to_float with hand-derived expectations.
module tb_fixed_to_float;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [30:0] fixed_in;
    logic [31:0] float_out;
    logic        complete;

    int compared   = 0;
    int mismatched = 0;

    fixed_to_float #(.IN_W(31), .FRAC_BITS(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fixed_in  (fixed_in),
        .float_out (float_out),
        .complete  (complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge. Accept edge is edge 1; latency is the edge after
    // which complete is first seen high. With hold, start stays high and the
    // task returns at the negedge where complete is high.
    task automatic convert(input logic [30:0] v, input logic [31:0] expf,
                           input int explat, input bit hold, input string tag);
        int lat;
        start    = 1'b1;
        fixed_in = v;
        @(posedge clk);
        @(negedge clk);
        lat      = 1;
        start    = hold;
        fixed_in = 31'($urandom);
        while (!complete && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (!complete) fixed_in = 31'($urandom);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(explat));
        chk({tag, "_val"}, float_out, expf);
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_pulse"}, {31'd0, complete}, 32'd0);
        end
    endtask

    initial begin
        int pulses;
        reset    = 1'b1;
        start    = 1'b0;
        fixed_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_complete", {31'd0, complete}, 32'd0);
        chk("rst_float", float_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert(31'h0800000, 32'h3F800000, 4, 1'b0, "one");
        convert(31'h0C00000, 32'h3FC00000, 4, 1'b0, "one_half3");
        convert(31'h0400000, 32'h3F000000, 5, 1'b0, "half");
        convert(31'h0000001, 32'h34000000, 27, 1'b0, "lsb");
        convert(31'h7FFFFFFF, 32'h437FFFFF, 11, 1'b0, "max");
        convert(31'h0000000, 32'h00000000, 3, 1'b0, "zero");

        // Back-to-back with start held high and junk fixed_in while busy.
        convert(31'h0800000, 32'h3F800000, 4, 1'b1, "b2b_one");
        convert(31'h0000003, 32'h34C00000, 26, 1'b1, "b2b_three");
        convert(31'h1000000, 32'h40000000, 5, 1'b1, "b2b_two");
        convert(31'h0000000, 32'h00000000, 3, 1'b1, "b2b_zero");
        convert(31'h0C00000, 32'h3FC00000, 4, 1'b0, "b2b_last");

        // Abort a conversion of the LSB while it is shifting left.
        @(negedge clk);
        convert(31'h0800000, 32'h3F800000, 4, 1'b0, "pre_abort");
        start    = 1'b1;
        fixed_in = 31'h0000001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_complete", {31'd0, complete}, 32'd0);
        chk("abort_float", float_out, 32'd0);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (complete) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        convert(31'h0800000, 32'h3F800000, 4, 1'b0, "post_abort");

        // Round trip through a float-to-fixed model with truncation.
        for (int i = 0; i < 1000; i++) begin
            int          e;
            int          sh;
            logic [22:0] m;
            logic [22:0] mt;
            int unsigned mant;
            int unsigned mask;
            logic [30:0] fx;
            e    = int'($urandom_range(134, 104));
            m    = 23'($urandom);
            sh   = e - 127;
            mant = {8'd0, 1'b1, m};
            mt   = m;
            if (sh >= 0) begin
                fx = 31'(mant << sh);
            end else begin
                fx   = 31'(mant >> (-sh));
                mask = (32'd1 << (-sh)) - 32'd1;
                mt   = m & ~23'(mask);
            end
            convert(fx, {1'b0, 8'(e), mt}, 4 + ((sh < 0) ? -sh : sh), 1'b0, "rt");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
